// File: rtl/ftdi_link_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_sched_pkg
// Description : Shared types and constants for the FTDI link scheduler.
//               sched_state_t - scheduler state encoding (also the debug value)
//               grant_t       - which window type was granted last
//               FLUSH_CYCLES  - length of the clear pulse sent to the FTDI core
// Revision    : 1.0 - initial release
// ============================================================================
package ftdi_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        FLUSH = 3'd4
    } sched_state_t;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

    localparam int FLUSH_CYCLES = 2;

endpackage : ftdi_sched_pkg
`default_nettype wire

// File: rtl/ftdi_link_scheduler_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sched_sat_counter
// Description : Saturating up-counter with synchronous clear. Holds at
//               all-ones instead of wrapping.
// Ports       : clock, reset_n (async, active-low)
//               i_clr   - synchronous clear (wins over i_en)
//               i_en    - count enable
//               o_count - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sched_sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : sched_sat_counter
`default_nettype wire

// File: rtl/ftdi_link_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_link_scheduler
// Description : Time-slices the shared FTDI ADBUS between host->board read
//               windows and board->host packet write windows. Stages one
//               packet with load_1k, gates wr_en/rd_en, owns the FTDI clear,
//               and flushes the interface if a window stalls (watchdog).
// Ports       : clock, reset_n (async, active-low)
//               in : pkt_ready, host_rd_req, sw_abort, wrq_empty, rdq_full,
//                    rd_qsize[16:0]
//               out: load_1k, wr_en, rd_en, clear, pkt_sent, timeout_err,
//                    state_dbg[2:0]
//               FTDI_SCHED_STATS_EN adds pkt_count[15:0], rd_windows[15:0]
// Revision    : 1.0 - initial release
// ============================================================================
module ftdi_link_scheduler
    import ftdi_sched_pkg::*;
#(
    parameter int PKT_BYTES = 1024,
    parameter int WR_SLICE  = 2048,
    parameter int RD_SLICE  = 4096,
    parameter int RD_HIGH   = 120000,
    parameter int TIMEOUT   = 65535
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pkt_ready,
    input  logic        host_rd_req,
    input  logic        sw_abort,
    input  logic        wrq_empty,
    input  logic        rdq_full,
    input  logic [16:0] rd_qsize,
    output logic        load_1k,
    output logic        wr_en,
    output logic        rd_en,
    output logic        clear,
    output logic        pkt_sent,
    output logic        timeout_err,
`ifdef FTDI_SCHED_STATS_EN
    output logic [15:0] pkt_count,
    output logic [15:0] rd_windows,
`endif
    output logic [2:0]  state_dbg
);

    // Last cycle index of each timed state (counter starts at 0 on entry).
    localparam logic [16:0] c_load_last  = 17'(PKT_BYTES + 3);
    localparam logic [16:0] c_wr_last    = 17'(WR_SLICE - 1);
    localparam logic [16:0] c_rd_last    = 17'(RD_SLICE - 1);
    localparam logic [16:0] c_flush_last = 17'(FLUSH_CYCLES - 1);
    localparam logic [16:0] c_rd_high    = 17'(RD_HIGH);
    localparam logic [15:0] c_wd_last    = 16'(TIMEOUT - 1);

    generate
        if (PKT_BYTES < 1 || PKT_BYTES > 1024) begin : g_chk_pkt_bytes
            $error("PKT_BYTES must be in 1..1024");
        end
        if (RD_HIGH < 0 || RD_HIGH >= 131072) begin : g_chk_rd_high
            $error("RD_HIGH must be below 2^17");
        end
        if (WR_SLICE < 1 || WR_SLICE > 131072 || RD_SLICE < 1 || RD_SLICE > 131072) begin : g_chk_slices
            $error("WR_SLICE/RD_SLICE must be in 1..2^17");
        end
        if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_chk_timeout
            $error("TIMEOUT must be in 1..65535");
        end
    endgenerate

    sched_state_t r_state;
    sched_state_t w_next;
    grant_t       r_last_grant;

    logic [16:0] w_slice_cnt;
    logic [15:0] w_wd_cnt;
    logic        w_cnt_clr;
    logic        w_wd_active;
    logic        w_wd_trip;
    logic        w_cand_w;
    logic        w_cand_r;

    assign w_cand_w    = pkt_ready & ~wrq_empty;
    assign w_cand_r    = host_rd_req & ~rdq_full & (rd_qsize < c_rd_high);
    assign w_wd_active = (r_state == LOAD) || (r_state == WRITE) || (r_state == READ);
    assign w_wd_trip   = w_wd_active && (w_wd_cnt >= c_wd_last);
    // An abort into FLUSH while already in FLUSH restarts the clear pulse,
    // so the counters must clear even though the state does not change.
    assign w_cnt_clr   = (w_next != r_state) || sw_abort;

    sched_sat_counter #(.W(17)) u_slice_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clr   (w_cnt_clr),
        .i_en    (1'b1),
        .o_count (w_slice_cnt)
    );

    sched_sat_counter #(.W(16)) u_wd_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clr   (w_cnt_clr),
        .i_en    (w_wd_active),
        .o_count (w_wd_cnt)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                // Round robin: on contention, grant the type not served last.
                if (w_cand_w && (!w_cand_r || (r_last_grant == GRANT_READ))) begin
                    w_next = LOAD;
                end else if (w_cand_r) begin
                    w_next = READ;
                end
            end
            LOAD:  if (w_slice_cnt >= c_load_last) w_next = WRITE;
            WRITE: if (w_slice_cnt >= c_wr_last) w_next = IDLE;
            READ: begin
                if ((w_slice_cnt >= c_rd_last) || rdq_full ||
                    (rd_qsize >= c_rd_high) || !host_rd_req) begin
                    w_next = IDLE;
                end
            end
            FLUSH: if (w_slice_cnt >= c_flush_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_wd_trip) w_next = FLUSH;
        if (sw_abort)  w_next = FLUSH;
    end

    // Outputs are registered from the next state so they line up exactly
    // with the state register (Moore timing, no combinational paths out).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_READ;
            load_1k      <= 1'b0;
            wr_en        <= 1'b0;
            rd_en        <= 1'b0;
            clear        <= 1'b0;
            pkt_sent     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            r_state  <= w_next;
            load_1k  <= (r_state == IDLE) && (w_next == LOAD);
            wr_en    <= (w_next == WRITE);
            rd_en    <= (w_next == READ);
            clear    <= (w_next == FLUSH);
            pkt_sent <= (r_state == WRITE) && (w_next == IDLE);
            if ((r_state == WRITE) && (w_next == IDLE)) begin
                r_last_grant <= GRANT_WRITE;
            end else if ((r_state == READ) && (w_next == IDLE)) begin
                r_last_grant <= GRANT_READ;
            end
            // An abort in the same cycle takes precedence over the watchdog.
            if (w_wd_trip && !sw_abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign state_dbg = r_state;

`ifdef FTDI_SCHED_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count  <= '0;
            rd_windows <= '0;
        end else if (w_next == FLUSH) begin
            pkt_count  <= '0;
            rd_windows <= '0;
        end else begin
            if ((r_state == WRITE) && (w_next == IDLE)) begin
                pkt_count <= pkt_count + 16'd1;
            end
            if ((r_state != READ) && (w_next == READ)) begin
                rd_windows <= rd_windows + 16'd1;
            end
        end
    end
`endif

endmodule : ftdi_link_scheduler
`default_nettype wire

// File: tb/tb_ftdi_link_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ftdi_link_scheduler
// Description : Directed self-checking bench for ftdi_link_scheduler.
//               dut  - default parameters (packet, arbitration, read exits,
//                      abort)
//               dut2 - PKT_BYTES=16, WR_SLICE=1000, TIMEOUT=100 (watchdog)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ftdi_link_scheduler;

    localparam int S_IDLE  = 0;
    localparam int S_LOAD  = 1;
    localparam int S_WRITE = 2;
    localparam int S_READ  = 3;
    localparam int S_FLUSH = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Primary DUT signals
    logic        reset_n;
    logic        pkt_ready, host_rd_req, sw_abort, wrq_empty, rdq_full;
    logic [16:0] rd_qsize;
    logic        load_1k, wr_en, rd_en, clear, pkt_sent, timeout_err;
    logic [2:0]  state_dbg;

    // Watchdog DUT signals
    logic        reset_n2;
    logic        pkt_ready2, host_rd_req2, sw_abort2, wrq_empty2, rdq_full2;
    logic [16:0] rd_qsize2;
    logic        load_1k2, wr_en2, rd_en2, clear2, pkt_sent2, timeout_err2;
    logic [2:0]  state_dbg2;

`ifdef FTDI_SCHED_STATS_EN
    logic [15:0] pkt_count, rd_windows, pkt_count2, rd_windows2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ftdi_link_scheduler dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pkt_ready   (pkt_ready),
        .host_rd_req (host_rd_req),
        .sw_abort    (sw_abort),
        .wrq_empty   (wrq_empty),
        .rdq_full    (rdq_full),
        .rd_qsize    (rd_qsize),
        .load_1k     (load_1k),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .clear       (clear),
        .pkt_sent    (pkt_sent),
        .timeout_err (timeout_err),
`ifdef FTDI_SCHED_STATS_EN
        .pkt_count   (pkt_count),
        .rd_windows  (rd_windows),
`endif
        .state_dbg   (state_dbg)
    );

    ftdi_link_scheduler #(
        .PKT_BYTES (16),
        .WR_SLICE  (1000),
        .TIMEOUT   (100)
    ) dut2 (
        .clock       (clock),
        .reset_n     (reset_n2),
        .pkt_ready   (pkt_ready2),
        .host_rd_req (host_rd_req2),
        .sw_abort    (sw_abort2),
        .wrq_empty   (wrq_empty2),
        .rdq_full    (rdq_full2),
        .rd_qsize    (rd_qsize2),
        .load_1k     (load_1k2),
        .wr_en       (wr_en2),
        .rd_en       (rd_en2),
        .clear       (clear2),
        .pkt_sent    (pkt_sent2),
        .timeout_err (timeout_err2),
`ifdef FTDI_SCHED_STATS_EN
        .pkt_count   (pkt_count2),
        .rd_windows  (rd_windows2),
`endif
        .state_dbg   (state_dbg2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int nload;
        int nbad;

        // ---------------- 1: reset with all inputs high ----------------
        reset_n     = 1'b0;
        pkt_ready   = 1'b1;
        host_rd_req = 1'b1;
        sw_abort    = 1'b1;
        wrq_empty   = 1'b1;
        rdq_full    = 1'b1;
        rd_qsize    = '1;
        reset_n2     = 1'b0;
        pkt_ready2   = 1'b1;
        host_rd_req2 = 1'b0;
        sw_abort2    = 1'b0;
        wrq_empty2   = 1'b0;
        rdq_full2    = 1'b0;
        rd_qsize2    = '0;
        repeat (3) tick();
        check("rst_load_1k",     load_1k,     0);
        check("rst_wr_en",       wr_en,       0);
        check("rst_rd_en",       rd_en,       0);
        check("rst_clear",       clear,       0);
        check("rst_pkt_sent",    pkt_sent,    0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_state",       state_dbg,   S_IDLE);

        // Both candidates true; last grant resets to READ so WRITE wins.
        sw_abort  = 1'b0;
        wrq_empty = 1'b0;
        rdq_full  = 1'b0;
        rd_qsize  = '0;
        reset_n   = 1'b1;
        tick();
        check("rst_first_load_1k", load_1k,   1);
        check("rst_first_state",   state_dbg, S_LOAD);

        // ---------------- 2: packet path ----------------
        host_rd_req = 1'b0;
        n = 0; nload = 0; nbad = 0;
        while (state_dbg == 3'(S_LOAD) && n < 5000) begin
            if (load_1k) nload++;
            if (wr_en || rd_en || clear) nbad++;
            n++;
            if (n == 10) pkt_ready = 1'b0;  // dropping mid-window must not abort
            tick();
        end
        check("pkt_load_cycles",  n,     1028);
        check("pkt_load_1k_once", nload, 1);
        check("pkt_load_quiet",   nbad,  0);
        check("pkt_write_state",  state_dbg, S_WRITE);
        n = 0; nbad = 0;
        while (wr_en && n < 5000) begin
            if (pkt_sent || load_1k) nbad++;
            n++;
            tick();
        end
        check("pkt_write_cycles",   n,         2048);
        check("pkt_write_no_pulse", nbad,      0);
        check("pkt_sent_pulse",     pkt_sent,  1);
        check("pkt_end_state",      state_dbg, S_IDLE);
`ifdef FTDI_SCHED_STATS_EN
        check("pkt_count_one", pkt_count, 1);
`endif
        tick();
        check("pkt_sent_single", pkt_sent,  0);
        check("pkt_idle_hold",   state_dbg, S_IDLE);

        // ---------------- 3: arbitration (last grant = WRITE) ----------------
        pkt_ready   = 1'b1;
        host_rd_req = 1'b1;
        tick();
        check("arb_read_first", state_dbg, S_READ);
        check("arb_rd_en",      rd_en,     1);
        n = 0;
        while (rd_en && n < 6000) begin
            n++;
            tick();
        end
        check("arb_read_cycles", n,         4096);
        check("arb_read_end",    state_dbg, S_IDLE);
        tick();
        check("arb_write_next", state_dbg, S_LOAD);
        check("arb_load_1k",    load_1k,   1);
        n = 0;
        while (!pkt_sent && n < 4000) begin
            n++;
            tick();
        end
        check("arb_pkt_sent_seen", pkt_sent, 1);
        tick();
        check("arb_read_again", state_dbg, S_READ);
`ifdef FTDI_SCHED_STATS_EN
        check("arb_pkt_count_two", pkt_count, 2);
`endif

        // ---------------- 4: read early exits ----------------
        repeat (5) tick();
        rd_qsize  = 17'd120000;
        pkt_ready = 1'b0;
        check("rx_qsize_still_on", rd_en, 1);
        tick();
        check("rx_qsize_rd_en",  rd_en,     0);
        check("rx_qsize_state",  state_dbg, S_IDLE);
        tick();
        check("rx_qsize_no_grant", state_dbg, S_IDLE);
        rd_qsize = 17'd119999;
        tick();
        check("rx_below_high_grant", state_dbg, S_READ);
        repeat (3) tick();
        rdq_full = 1'b1;
        tick();
        check("rx_full_rd_en", rd_en,     0);
        check("rx_full_state", state_dbg, S_IDLE);
        rdq_full = 1'b0;
        tick();
        check("rx_full_regrant", rd_en, 1);
        repeat (3) tick();
        host_rd_req = 1'b0;
        tick();
        check("rx_req_rd_en", rd_en,     0);
        check("rx_req_state", state_dbg, S_IDLE);
        tick();
        check("rx_req_idle", state_dbg, S_IDLE);

        // ---------------- 6: abort mid-LOAD ----------------
        rd_qsize  = '0;
        pkt_ready = 1'b1;
        tick();
        check("ab_load", state_dbg, S_LOAD);
        pkt_ready = 1'b0;
        repeat (5) tick();
        sw_abort = 1'b1;
        tick();
        sw_abort = 1'b0;
        check("ab_flush_state", state_dbg, S_FLUSH);
        check("ab_clear_1",     clear,     1);
        check("ab_no_wr_en",    wr_en,     0);
        // Abort again inside FLUSH restarts the two-cycle clear.
        sw_abort = 1'b1;
        tick();
        sw_abort = 1'b0;
        check("ab_restart_clear", clear,     1);
        check("ab_restart_state", state_dbg, S_FLUSH);
        tick();
        check("ab_clear_2", clear, 1);
        tick();
        check("ab_clear_done", clear,     0);
        check("ab_idle",       state_dbg, S_IDLE);
        check("ab_no_pkt",     pkt_sent,  0);
`ifdef FTDI_SCHED_STATS_EN
        check("ab_pkt_count_zero", pkt_count, 0);
`endif
        check("ab_no_timeout", timeout_err, 0);

        // ---------------- 5: watchdog (dut2) ----------------
        reset_n2 = 1'b1;
        tick();
        check("wd_load", state_dbg2, S_LOAD);
        n = 0;
        while (state_dbg2 == 3'(S_LOAD) && n < 200) begin
            n++;
            tick();
        end
        check("wd_load_cycles", n, 20);
        n = 0;
        while (wr_en2 && n < 2000) begin
            n++;
            tick();
        end
        pkt_ready2 = 1'b0;
        check("wd_write_cycles", n,            100);
        check("wd_flush_state",  state_dbg2,   S_FLUSH);
        check("wd_clear_1",      clear2,       1);
        check("wd_timeout_err",  timeout_err2, 1);
        check("wd_no_pkt_sent",  pkt_sent2,    0);
        tick();
        check("wd_clear_2", clear2, 1);
        tick();
        check("wd_clear_done", clear2,     0);
        check("wd_idle",       state_dbg2, S_IDLE);
        repeat (3) tick();
        check("wd_err_sticky", timeout_err2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ftdi_link_scheduler
`default_nettype wire
